// File: rtl/result_checker.sv
// Waits for the three convolution engines' outputs to settle, then latches the
// 1x1 PE golden result and compares the 3x3 and 2x2 engines against it.
module result_checker #(
  parameter int DW            = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [DW-1:0] o00_pe,
  input  logic [DW-1:0] o01_pe,
  input  logic [DW-1:0] o10_pe,
  input  logic [DW-1:0] o11_pe,
  input  logic [DW-1:0] o00_3b3,
  input  logic [DW-1:0] o01_3b3,
  input  logic [DW-1:0] o10_3b3,
  input  logic [DW-1:0] o11_3b3,
  input  logic [DW-1:0] o00_2b2,
  input  logic [DW-1:0] o01_2b2,
  input  logic [DW-1:0] o10_2b2,
  input  logic [DW-1:0] o11_2b2,
  output logic          busy,
  output logic          done,
  output logic          match_3b3,
  output logic          match_2b2,
  output logic          timeout,
  output logic [7:0]    mismatch_mask,
  output logic [DW-1:0] gold00,
  output logic [DW-1:0] gold01,
  output logic [DW-1:0] gold10,
  output logic [DW-1:0] gold11,
  output logic [7:0]    settle_cycles
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} state_t;

  state_t state, next_state;

  logic [3:0][DW-1:0] pe_v, t3_v, t2_v;
  logic [3:0][DW-1:0] prev_pe, prev_3b3, prev_2b2;
  logic [CW-1:0]      cnt_pe, cnt_3b3, cnt_2b2;
  logic [7:0]         settle_next;
  logic [7:0]         mask_cmp;
  logic               all_settled;
  logic               timeout_hit;

  // Element index 0..3 maps to positions 00, 01, 10, 11.
  assign pe_v = {o11_pe,  o10_pe,  o01_pe,  o00_pe};
  assign t3_v = {o11_3b3, o10_3b3, o01_3b3, o00_3b3};
  assign t2_v = {o11_2b2, o10_2b2, o01_2b2, o00_2b2};

  assign settle_next = (settle_cycles == 8'hFF) ? 8'hFF : settle_cycles + 8'd1;
  assign all_settled = (cnt_pe == CNT_MAX) && (cnt_3b3 == CNT_MAX) && (cnt_2b2 == CNT_MAX);
  assign timeout_hit = (settle_next == 8'(TIMEOUT));

  assign busy = (state == RUN) || (state == CMP);
  assign done = (state == DONE);

  function automatic logic [CW-1:0] cnt_upd(input logic [3:0][DW-1:0] cur,
                                            input logic [3:0][DW-1:0] prev,
                                            input logic [CW-1:0]      cnt);
    if (cur != prev)         return '0;
    else if (cnt == CNT_MAX) return cnt;
    else                     return cnt + 1'b1;
  endfunction

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    mask_cmp = '0;
    for (int i = 0; i < 4; i++) begin
      mask_cmp[i]     = (t3_v[i] != pe_v[i]);
      mask_cmp[4 + i] = (t2_v[i] != pe_v[i]);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN: begin
        if (start)            next_state = RUN;
        else if (all_settled) next_state = CMP;
        else if (timeout_hit) next_state = DONE;
      end
      CMP:  next_state = start ? RUN : DONE;
      DONE: if (start) next_state = RUN;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_pe       <= '0;
      prev_3b3      <= '0;
      prev_2b2      <= '0;
      cnt_pe        <= '0;
      cnt_3b3       <= '0;
      cnt_2b2       <= '0;
      settle_cycles <= '0;
      timeout       <= 1'b0;
      match_3b3     <= 1'b0;
      match_2b2     <= 1'b0;
      mismatch_mask <= '0;
      {gold11, gold10, gold01, gold00} <= '0;
    end else if (start) begin
      // A start in any state begins a fresh run; stale results are dropped.
      prev_pe       <= pe_v;
      prev_3b3      <= t3_v;
      prev_2b2      <= t2_v;
      cnt_pe        <= '0;
      cnt_3b3       <= '0;
      cnt_2b2       <= '0;
      settle_cycles <= '0;
      timeout       <= 1'b0;
      match_3b3     <= 1'b0;
      match_2b2     <= 1'b0;
      mismatch_mask <= '0;
    end else if (state == RUN) begin
      settle_cycles <= settle_next;
      prev_pe       <= pe_v;
      prev_3b3      <= t3_v;
      prev_2b2      <= t2_v;
      cnt_pe        <= cnt_upd(pe_v, prev_pe, cnt_pe);
      cnt_3b3       <= cnt_upd(t3_v, prev_3b3, cnt_3b3);
      cnt_2b2       <= cnt_upd(t2_v, prev_2b2, cnt_2b2);
      // Settling wins over a simultaneous timeout.
      if (!all_settled && timeout_hit) begin
        timeout       <= 1'b1;
        match_3b3     <= 1'b0;
        match_2b2     <= 1'b0;
        mismatch_mask <= 8'hFF;
        {gold11, gold10, gold01, gold00} <= pe_v;
      end
    end else if (state == CMP) begin
      {gold11, gold10, gold01, gold00} <= pe_v;
      mismatch_mask <= mask_cmp;
      match_3b3     <= ~|mask_cmp[3:0];
      match_2b2     <= ~|mask_cmp[7:4];
    end
  end

endmodule

// File: tb/tb_result_checker.sv
// Scoreboard bench for result_checker: expected results are queued at each
// start and compared when done rises.
module tb_result_checker;

  localparam int DW = 8;

  typedef struct {
    int         done_k;
    logic       m3;
    logic       m2;
    logic       tmo;
    logic [7:0] mask;
    logic [7:0] settle;
    logic [7:0] g00;
    logic [7:0] g11;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [DW-1:0] pe [4];
  logic [DW-1:0] t3 [4];
  logic [DW-1:0] t2 [4];
  logic          busy, done, match_3b3, match_2b2, timeout;
  logic [7:0]    mismatch_mask, settle_cycles;
  logic [DW-1:0] gold00, gold01, gold10, gold11;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  result_checker #(.DW(DW), .STABLE_CYCLES(4), .TIMEOUT(64)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .o00_pe(pe[0]),  .o01_pe(pe[1]),  .o10_pe(pe[2]),  .o11_pe(pe[3]),
    .o00_3b3(t3[0]), .o01_3b3(t3[1]), .o10_3b3(t3[2]), .o11_3b3(t3[3]),
    .o00_2b2(t2[0]), .o01_2b2(t2[1]), .o10_2b2(t2[2]), .o11_2b2(t2[3]),
    .busy(busy), .done(done), .match_3b3(match_3b3), .match_2b2(match_2b2),
    .timeout(timeout), .mismatch_mask(mismatch_mask),
    .gold00(gold00), .gold01(gold01), .gold10(gold10), .gold11(gold11),
    .settle_cycles(settle_cycles)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic set_all(input logic [7:0] base);
    for (int i = 0; i < 4; i++) begin
      pe[i] = base;
      t3[i] = base;
      t2[i] = base;
    end
  endtask

  // Per-cycle stimulus, applied just after RUN edge k.
  task automatic apply(input int mode, input int k, input logic [7:0] base);
    case (mode)
      1: t3[1] = (k < 8) ? 8'(8'h40 + k) : base;
      3: pe[3] = (k % 2 == 0) ? 8'(base + 8'd1) : base;
      default: ;
    endcase
  endtask

  // mode 0 const, 1 3x3 churn, 2 2x2 off-by-one, 3 pe toggling, 4 3x3 extreme mismatch
  task automatic run_case(input int mode, input logic [7:0] base, input int restart_at, input exp_t e);
    exp_t got;
    int   k;
    sb.push_back(e);
    set_all(base);
    if (mode == 2) t2[1] = 8'(base + 8'd1);
    if (mode == 4) t3[2] = 8'hFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    apply(mode, 0, base);
    while (!done && k < 300) begin
      @(posedge clk); #1;
      k++;
      start = (k == restart_at);
      apply(mode, k, base);
      if (k == 1) begin
        check("busy_in_run", busy, 1'b1);
        check("timeout_cleared", timeout, 1'b0);
        check("mask_cleared", mismatch_mask, 8'h00);
      end
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
    got = sb.pop_front();
    check("done_cycle", k, got.done_k);
    check("match_3b3", match_3b3, got.m3);
    check("match_2b2", match_2b2, got.m2);
    check("timeout", timeout, got.tmo);
    check("mismatch_mask", mismatch_mask, got.mask);
    check("settle_cycles", settle_cycles, got.settle);
    check("gold00", gold00, got.g00);
    check("gold11", gold11, got.g11);
    check("busy_in_done", busy, 1'b0);
    @(posedge clk); #1;
    check("done_held", done, 1'b1);
    check("settle_held", settle_cycles, got.settle);
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    set_all(8'h00);
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_settle", settle_cycles, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    // done_k, m3, m2, tmo, mask, settle, g00, g11
    run_case(0, 8'h12, -1, '{6,  1'b1, 1'b1, 1'b0, 8'h00, 8'd5,  8'h12, 8'h12});
    run_case(1, 8'h12, -1, '{15, 1'b1, 1'b1, 1'b0, 8'h00, 8'd14, 8'h12, 8'h12});
    run_case(2, 8'h12, -1, '{6,  1'b1, 1'b0, 1'b0, 8'h20, 8'd5,  8'h12, 8'h12});
    run_case(3, 8'h12, -1, '{64, 1'b0, 1'b0, 1'b1, 8'hFF, 8'd64, 8'h12, 8'h12});
    run_case(4, 8'h00, -1, '{6,  1'b0, 1'b1, 1'b0, 8'h04, 8'd5,  8'h00, 8'h00});
    run_case(0, 8'h5A, 2,  '{9,  1'b1, 1'b1, 1'b0, 8'h00, 8'd5,  8'h5A, 8'h5A});

    // Asynchronous reset in the middle of a run.
    set_all(8'h33);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_settle", settle_cycles, 8'h00);
    check("arst_gold00", gold00, 8'h00);
    check("arst_mask", mismatch_mask, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_no_done", done, 1'b0);
    check("idle_not_busy", busy, 1'b0);

    run_case(0, 8'hA5, -1, '{6, 1'b1, 1'b1, 1'b0, 8'h00, 8'd5, 8'hA5, 8'hA5});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
